// File: rtl/mul_acc_border_pkg.sv
// mul_acc_pkg: shared state type, partial-sum limits and saturating add
package mul_acc_pkg;
   localparam int PSUM_W = 16;
   localparam int CNT_W = 8;
   typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
   localparam logic [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
   localparam logic [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
   function automatic logic [PSUM_W-1:0] sat_add(input logic [PSUM_W:0] a, input logic [PSUM_W:0] b);
      logic [PSUM_W:0] s;
      s = a + b;
      return (s[PSUM_W] != s[PSUM_W-1]) ? (s[PSUM_W] ? PSUM_MIN : PSUM_MAX) : s[PSUM_W-1:0];
   endfunction
endpackage

// File: rtl/mul_acc_border_if.sv
// mul_acc_border_if: window control, bit stream and partial-sum bus of the border accumulator
interface mul_acc_border_if #(parameter int WIDTH = 16, parameter int CWIDTH = 8);
   logic              i_start;
   logic [CWIDTH-1:0] i_len;
   logic              i_bit;
   logic [WIDTH-1:0]  i_psum;
   logic              i_psum_valid;
   logic [WIDTH-1:0]  o_psum;
   logic              o_valid;
   logic              o_busy;
   modport master (output i_start, i_len, i_bit, i_psum, i_psum_valid, input o_psum, o_valid, o_busy);
   modport slave (input i_start, i_len, i_bit, i_psum, i_psum_valid, output o_psum, o_valid, o_busy);
endinterface

// File: rtl/mul_acc_border_bipolar_counter.sv
// bipolar_counter: counts window cycles and ones, yields 2*ones - len and the last-bit flag
module bipolar_counter #(parameter int CWIDTH = 8) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_start,
   input  logic                     i_en,
   input  logic                     i_bit,
   input  logic [CWIDTH-1:0]        i_len,
   output logic signed [CWIDTH+1:0] o_count,
   output logic                     o_last
);
   logic [CWIDTH:0] cnt_q, cnt_d, ones_q, ones_d, len_q, len_d;
   // start clears the counters and latches the window (0 means 2^CWIDTH); en advances them
   always_comb begin
      len_d = i_start ? ((i_len == '0) ? {1'b1, {CWIDTH{1'b0}}} : {1'b0, i_len}) : len_q;
      cnt_d = i_start ? '0 : i_en ? cnt_q + 1'b1 : cnt_q;
      ones_d = i_start ? '0 : i_en ? ones_q + {{CWIDTH{1'b0}}, i_bit} : ones_q;
   end
   // counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ones_q <= '0;
         len_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         ones_q <= ones_d;
         len_q <= len_d;
      end
   end
   assign o_last = i_en & (cnt_q == len_q - 1'b1);
   // 2*ones can reach 2^(CWIDTH+1), but the wrapped difference is exact because the result fits
   assign o_count = $signed({ones_q, 1'b0} - {1'b0, len_q});
endmodule

// File: rtl/mul_acc_border.sv
// mul_acc_border: turns a bipolar product stream into a signed count and adds it to the upstream psum
module mul_acc_border
   import mul_acc_pkg::*;
#(
   parameter int WIDTH = PSUM_W,
   parameter int CWIDTH = CNT_W
) (
   input logic           clk,
   input logic           rst_n,
   mul_acc_border_if.slave bus
);
   state_t state_q, state_d;
   logic [WIDTH-1:0] psum_q, psum_d, o_psum_q, o_psum_d, src;
   logic have_q, have_d, o_valid_q, o_valid_d, take, done, last;
   logic signed [CWIDTH+1:0] count;
   bipolar_counter #(.CWIDTH(CWIDTH)) u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .i_start(bus.i_start),
      .i_en(state_q == RUN),
      .i_bit(bus.i_bit),
      .i_len(bus.i_len),
      .o_count(count),
      .o_last(last)
   );
   assign take = !bus.i_start && state_q != IDLE && bus.i_psum_valid && !have_q;
   assign done = !bus.i_start && state_q == WAIT && (have_q || bus.i_psum_valid);
   assign src = have_q ? psum_q : bus.i_psum;
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end
   // next state: start restarts from anywhere, last bit moves to WAIT, a usable psum finishes
   always_comb begin
      state_d = bus.i_start ? RUN : (state_q == RUN && last) ? WAIT : done ? IDLE : state_q;
   end
   // first psum in a window wins; result is registered on completion
   always_comb begin
      psum_d = take ? bus.i_psum : psum_q;
      have_d = bus.i_start ? 1'b0 : take ? 1'b1 : have_q;
      o_valid_d = done;
      o_psum_d = done ? sat_add({src[WIDTH-1], src}, {{(WIDTH-CWIDTH-1){count[CWIDTH+1]}}, count}) : o_psum_q;
   end
   // datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psum_q <= '0;
         have_q <= 1'b0;
         o_valid_q <= 1'b0;
         o_psum_q <= '0;
      end else begin
         psum_q <= psum_d;
         have_q <= have_d;
         o_valid_q <= o_valid_d;
         o_psum_q <= o_psum_d;
      end
   end
   // outputs come straight from registered state
   always_comb begin
      bus.o_busy = state_q != IDLE;
      bus.o_valid = o_valid_q;
      bus.o_psum = o_psum_q;
   end
endmodule

// File: tb/tb_mul_acc_border.sv
// tb_mul_acc_border: directed vector table plus hand-written corner sequences
module tb_mul_acc_border;
   typedef struct {
      logic [7:0] len;
      int         pat;
      int         psum;
      int         exp;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_pass = 0, n_total = 0, n_valid = 0, v0 = 0;
   vec_t vecs[8];
   always #5 clk = ~clk;
   mul_acc_border_if #(.WIDTH(16), .CWIDTH(8)) bus ();
   mul_acc_border #(.WIDTH(16), .CWIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always @(negedge clk) if (bus.o_valid) n_valid++;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask
   function automatic logic bit_of(input int pat, input int i);
      return (pat == 1) ? 1'b1 : (pat == 2) ? ((i % 2) == 0) : 1'b0;
   endfunction
   task automatic start(input logic [7:0] len);
      bus.i_start = 1'b1;
      bus.i_len = len;
      tick();
      bus.i_start = 1'b0;
   endtask
   task automatic bits(input int n, input int pat, input int pv_at, input int psum);
      for (int i = 0; i < n; i++) begin
         bus.i_bit = bit_of(pat, i);
         bus.i_psum_valid = (i == pv_at);
         bus.i_psum = 16'(psum);
         tick();
      end
      bus.i_bit = 1'b0;
      bus.i_psum_valid = 1'b0;
   endtask
   task automatic run_vec(input int k, input vec_t v);
      int n;
      n = (v.len == 0) ? 256 : int'(v.len);
      start(v.len);
      bits(n, v.pat, 0, v.psum);
      check($sformatf("v%0d busy_in_wait", k), int'(bus.o_busy), 1);
      check($sformatf("v%0d no_early_valid", k), int'(bus.o_valid), 0);
      tick();
      check($sformatf("v%0d valid", k), int'(bus.o_valid), 1);
      check($sformatf("v%0d psum", k), int'($signed(bus.o_psum)), v.exp);
      check($sformatf("v%0d busy_drop", k), int'(bus.o_busy), 0);
      tick();
      check($sformatf("v%0d valid_pulse", k), int'(bus.o_valid), 0);
      check($sformatf("v%0d psum_hold", k), int'($signed(bus.o_psum)), v.exp);
   endtask
   initial begin
      vecs[0] = '{8'd0, 1, 100, 356};
      vecs[1] = '{8'd16, 2, -5, -5};
      vecs[2] = '{8'd16, 0, 0, -16};
      vecs[3] = '{8'd0, 1, 32767, 32767};
      vecs[4] = '{8'd0, 0, -32768, -32768};
      vecs[5] = '{8'd1, 1, 0, 1};
      vecs[6] = '{8'd255, 2, 10, 11};
      vecs[7] = '{8'd8, 0, -32760, -32768};
      bus.i_start = 1'b0;
      bus.i_len = '0;
      bus.i_bit = 1'b0;
      bus.i_psum = '0;
      bus.i_psum_valid = 1'b0;
      #12;
      check("rst_busy", int'(bus.o_busy), 0);
      check("rst_valid", int'(bus.o_valid), 0);
      check("rst_psum", int'($signed(bus.o_psum)), 0);
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);
      // late psum; a valid in IDLE must not be latched
      bus.i_psum_valid = 1'b1;
      bus.i_psum = 16'd1000;
      tick();
      start(8'd4);
      bits(4, 1, -1, 0);
      for (int i = 0; i < 10; i++) tick();
      check("late_no_valid", int'(bus.o_valid), 0);
      check("late_busy", int'(bus.o_busy), 1);
      bus.i_psum_valid = 1'b1;
      bus.i_psum = 16'd7;
      tick();
      bus.i_psum_valid = 1'b0;
      check("late_valid", int'(bus.o_valid), 1);
      check("late_psum", int'($signed(bus.o_psum)), 11);
      tick();
      // two valids in RUN: first one wins
      start(8'd4);
      bus.i_bit = 1'b1;
      bus.i_psum_valid = 1'b1;
      bus.i_psum = 16'd3;
      tick();
      bus.i_psum_valid = 1'b0;
      tick();
      bus.i_psum_valid = 1'b1;
      bus.i_psum = 16'd9;
      tick();
      bus.i_psum_valid = 1'b0;
      tick();
      bus.i_bit = 1'b0;
      tick();
      check("multi_valid", int'(bus.o_valid), 1);
      check("multi_psum", int'($signed(bus.o_psum)), 7);
      tick();
      // restart at cnt=5; a valid together with start is dropped
      v0 = n_valid;
      start(8'd16);
      bits(5, 0, 0, 20);
      bus.i_start = 1'b1;
      bus.i_len = 8'd16;
      bus.i_bit = 1'b1;
      bus.i_psum_valid = 1'b1;
      bus.i_psum = 16'd999;
      tick();
      bus.i_start = 1'b0;
      bits(16, 1, 0, 20);
      tick();
      check("restart_psum", int'($signed(bus.o_psum)), 36);
      tick();
      check("restart_one_pulse", n_valid - v0, 1);
      // asynchronous reset mid-RUN
      start(8'd16);
      bits(5, 1, 0, 50);
      #3 rst_n = 1'b0;
      #1;
      check("arst_busy", int'(bus.o_busy), 0);
      check("arst_psum", int'($signed(bus.o_psum)), 0);
      v0 = n_valid;
      tick();
      tick();
      rst_n = 1'b1;
      bus.i_bit = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      bus.i_bit = 1'b0;
      check("arst_no_valid", n_valid - v0, 0);
      check("arst_idle", int'(bus.o_busy), 0);
      // back-to-back windows, start during the o_valid cycle
      start(8'd8);
      bits(8, 1, 0, 0);
      tick();
      check("b2b_valid1", int'(bus.o_valid), 1);
      check("b2b_psum1", int'($signed(bus.o_psum)), 8);
      start(8'd8);
      check("b2b_pulse1", int'(bus.o_valid), 0);
      check("b2b_busy", int'(bus.o_busy), 1);
      bits(8, 0, 0, 0);
      tick();
      check("b2b_valid2", int'(bus.o_valid), 1);
      check("b2b_psum2", int'($signed(bus.o_psum)), -8);
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
